// File: rtl/ad7476a_sample_scheduler.sv
// ad7476a_sample_scheduler
// Round-robin arbiter that shares one ad7476a_interface between NUM_REQ
// requesters. Each grant issues a single-cycle conversion request, waits for
// the result under a watchdog, and returns the sample to the granted requester.
// Optional periodic trigger: define AD7476A_SCHED_PERIODIC_EN.
module ad7476a_sample_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned PERIOD_CYCLES  = 1000
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] done_o,
    output logic               err_o,
    output logic [11:0]        sample_o,
    output logic               busy_o,
    output logic               adc_request_o,
    input  logic [11:0]        adc_data_i,
    input  logic               adc_data_valid_i,
    output logic               periodic_valid_o,
    output logic               overrun_o
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] REQ_LAST  = PW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 64) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 64");
    end
    if (PERIOD_CYCLES < 2) begin : g_bad_period
        $error("PERIOD_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DATA,
        S_DELIVER
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_grant;
    logic            r_grant_per;
    logic [PW-1:0]   r_rr_ptr;
    logic [WW-1:0]   r_wdog;
    logic [11:0]     r_sample;
    logic            r_err;
    logic            w_any_req;
    logic [PW-1:0]   w_rr_pick;
    logic [PW-1:0]   w_idx;
    logic            w_timeout;
    logic            w_pending;
    logic            w_per_done;

    assign w_timeout  = (r_wdog == WDOG_LAST);
    assign w_per_done = (r_state == S_DELIVER) && r_grant_per;

    // Round-robin pick: first requester at or above r_rr_ptr, wrapping.
    always_comb begin
        w_any_req = 1'b0;
        w_rr_pick = '0;
        w_idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = PW'((32'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_any_req && req_i[w_idx]) begin
                w_any_req = 1'b1;
                w_rr_pick = w_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt   = r_state;
        done_o        = '0;
        adc_request_o = 1'b0;
        busy_o        = (r_state != S_IDLE);
        err_o         = r_err;
        sample_o      = r_sample;
        case (r_state)
            S_IDLE: begin
                if (w_pending || w_any_req) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                adc_request_o = 1'b1;
                w_state_nxt   = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (adc_data_valid_i || w_timeout) w_state_nxt = S_DELIVER;
            end
            S_DELIVER: begin
                if (!r_grant_per) done_o[r_grant] = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant, watchdog, result and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_grant     <= '0;
            r_grant_per <= 1'b0;
            r_rr_ptr    <= '0;
            r_wdog      <= '0;
            r_sample    <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pending) begin
                        r_grant_per <= 1'b1;
                    end else if (w_any_req) begin
                        r_grant_per <= 1'b0;
                        r_grant     <= w_rr_pick;
                    end
                end
                S_ISSUE: begin
                    r_wdog <= '0;
                end
                S_WAIT_DATA: begin
                    // Data beats a simultaneous watchdog expiry.
                    if (adc_data_valid_i) begin
                        r_sample <= adc_data_i;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_sample <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                S_DELIVER: begin
                    r_sample <= '0;
                    r_err    <= 1'b0;
                    if (!r_grant_per) begin
                        r_rr_ptr <= (r_grant == REQ_LAST) ? '0 : r_grant + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AD7476A_SCHED_PERIODIC_EN
    localparam int unsigned CW = $clog2(PERIOD_CYCLES);

    logic [CW-1:0] r_period_cnt;
    logic          r_pending;
    logic          w_tick;

    assign w_tick           = (r_period_cnt == CW'(PERIOD_CYCLES - 1));
    assign w_pending        = r_pending;
    assign periodic_valid_o = w_per_done;
    assign overrun_o        = w_tick && r_pending;

    // Free-running period counter and single-entry pending flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_period_cnt <= '0;
            r_pending    <= 1'b0;
        end else begin
            r_period_cnt <= w_tick ? '0 : r_period_cnt + CW'(1);
            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (w_per_done) begin
                r_pending <= 1'b0;
            end
        end
    end
`else
    assign w_pending        = 1'b0;
    assign periodic_valid_o = 1'b0;
    assign overrun_o        = 1'b0;
`endif

endmodule
